// File: rtl/aqua_sensor_pkg.sv
// Shared definitions for the aqua ultrasonic sensor path: FSM state
// encodings and the distance-to-echo-width conversion constants.
package aqua_sensor_pkg;

    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        MEDE_TRIGGER = 4'd1,
        ATRASO       = 4'd2,
        ECO          = 4'd3,
        PAUSA        = 4'd4
    } estado_t;

    localparam int unsigned US_PER_CM   = 58;
    localparam int unsigned MAX_DIST_CM = 400;
    localparam int unsigned MAX_ECHO_US = 38000;

    // Echo width in microseconds for a distance in cm. A zero or
    // beyond-range distance reports the sensor's "no object" width.
    function automatic logic [15:0] largura_eco_us(
        input logic [8:0]  cm,
        input int unsigned us_por_cm,
        input int unsigned max_cm,
        input int unsigned max_eco_us
    );
        logic [15:0] largura;
        if ((cm != '0) && (32'(cm) <= max_cm)) begin
            largura = 16'(32'(cm) * us_por_cm);
        end else begin
            largura = 16'(max_eco_us);
        end
        return largura;
    endfunction

endpackage

// File: rtl/hcsr04_emulador_contador_us.sv
// Microsecond timebase: a free-running tick generator (one pulse every
// TICK_CYCLES clocks) feeding a microsecond counter that flags the last
// tick of a loaded target. Restart clears both and loads a new target,
// so a target of N ends exactly N*TICK_CYCLES clocks after the restart.
module contador_us #(
    parameter int unsigned TICK_CYCLES = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reiniciar,
    input  logic [15:0] alvo,
    output logic        tick,
    output logic        fim
);

    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_ULTIMO = TW'(TICK_CYCLES - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [15:0]   us_q, us_d;
    logic [15:0]   alvo_q, alvo_d;

    assign tick = (tick_cnt_q == TICK_ULTIMO);
    // fim marks the edge on which the counter would reach the target
    assign fim  = tick && ((us_q + 16'd1) == alvo_q);

    // Next-state for the tick divider, microsecond count and target
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        us_d       = tick ? us_q + 16'd1 : us_q;
        alvo_d     = alvo_q;
        if (reiniciar) begin
            tick_cnt_d = '0;
            us_d       = '0;
            alvo_d     = alvo;
        end
    end

    // Timebase registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            us_q       <= '0;
            alvo_q     <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            us_q       <= us_d;
            alvo_q     <= alvo_d;
        end
    end

endmodule

// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder model: validates the trigger width, waits the sensor
// latency, then drives echo for a width proportional to the latched
// distance, followed by a holdoff before the next trigger is accepted.
module hcsr04_emulador #(
    parameter int unsigned TICK_CYCLES   = 50,
    parameter int unsigned MIN_TRIG_US   = 10,
    parameter int unsigned ECHO_DELAY_US = 400,
    parameter int unsigned US_PER_CM     = aqua_sensor_pkg::US_PER_CM,
    parameter int unsigned MAX_DIST_CM   = aqua_sensor_pkg::MAX_DIST_CM,
    parameter int unsigned MAX_ECHO_US   = aqua_sensor_pkg::MAX_ECHO_US,
    parameter int unsigned HOLDOFF_US    = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    input  logic        trigger,
    input  logic [8:0]  distancia_cm,
    output logic        echo,
    output logic        ocupado,
    output logic [15:0] medidas,
    output logic [3:0]  db_estado
);

    import aqua_sensor_pkg::*;

    localparam int unsigned MIN_TRIG_CYC = MIN_TRIG_US * TICK_CYCLES;
    localparam int unsigned CW           = $clog2(MIN_TRIG_CYC + 1);

    logic          trig_meta_q, trig_s_q, trig_ant_q;
    logic          trig_sobe, trig_desce;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [8:0]    dist_q, dist_d;
    logic [15:0]   medidas_q, medidas_d;
    logic          echo_q, echo_d;
    logic          ocupado_q, ocupado_d;

    logic          reiniciar;
    logic [15:0]   alvo;
    logic          tick_us;
    logic          fim;

    contador_us #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_contador_us (
        .clock    (clock),
        .reset    (reset),
        .reiniciar(reiniciar),
        .alvo     (alvo),
        .tick     (tick_us),
        .fim      (fim)
    );

    // Two-flop synchronizer for trigger plus a delayed copy for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_ant_q  <= 1'b0;
        end else begin
            trig_meta_q <= trigger;
            trig_s_q    <= trig_meta_q;
            trig_ant_q  <= trig_s_q;
        end
    end

    assign trig_sobe  = trig_s_q & ~trig_ant_q;
    assign trig_desce = ~trig_s_q & trig_ant_q;

    // Measurement sequencing; timed states restart the timebase on entry
    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        dist_d    = dist_q;
        medidas_d = medidas_q;
        reiniciar = 1'b0;
        alvo      = '0;

        if (!habilita) begin
            estado_d = OCIOSO;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (trig_sobe) begin
                        estado_d = MEDE_TRIGGER;
                        cont_d   = CW'(1);
                    end
                end
                MEDE_TRIGGER: begin
                    if (trig_desce) begin
                        if (cont_q >= CW'(MIN_TRIG_CYC)) begin
                            dist_d    = distancia_cm;
                            estado_d  = ATRASO;
                            reiniciar = 1'b1;
                            alvo      = 16'(ECHO_DELAY_US);
                        end else begin
                            estado_d = OCIOSO;
                        end
                    end else if (trig_s_q && (cont_q != '1)) begin
                        cont_d = cont_q + CW'(1);
                    end
                end
                ATRASO: begin
                    if (fim) begin
                        estado_d  = ECO;
                        reiniciar = 1'b1;
                        alvo      = largura_eco_us(dist_q, US_PER_CM,
                                                   MAX_DIST_CM, MAX_ECHO_US);
                    end
                end
                ECO: begin
                    if (fim) begin
                        estado_d  = PAUSA;
                        medidas_d = medidas_q + 16'd1;
                        reiniciar = 1'b1;
                        alvo      = 16'(HOLDOFF_US);
                    end
                end
                PAUSA: begin
                    if (fim) begin
                        estado_d = OCIOSO;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end

        // Outputs follow the next state so they are registered with it
        echo_d    = (estado_d == ECO);
        ocupado_d = (estado_d != OCIOSO);
    end

    // State, latched distance and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            dist_q    <= '0;
            medidas_q <= '0;
            echo_q    <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            dist_q    <= dist_d;
            medidas_q <= medidas_d;
            echo_q    <= echo_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign echo      = echo_q;
    assign ocupado   = ocupado_q;
    assign medidas   = medidas_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Directed bench for hcsr04_emulador with a scaled-down timebase:
// TICK_CYCLES=2, ECHO_DELAY_US=40, MAX_ECHO_US=3000, others default.
// Echo rises 3 + 40*2 = 83 cycles after trigger is driven low
// (2 synchronizer flops + 1 edge-detect cycle, then the latency).
module tb_hcsr04_emulador;

    localparam int DELAY_CYC = 83;

    logic        clock = 1'b0;
    logic        reset;
    logic        habilita;
    logic        trigger;
    logic [8:0]  distancia_cm;
    logic        echo;
    logic        ocupado;
    logic [15:0] medidas;
    logic [3:0]  db_estado;

    int cyc = 0;
    int erros = 0;
    int checks = 0;
    int t_desce, t_sobe, t_fim;

    hcsr04_emulador #(
        .TICK_CYCLES  (2),
        .MIN_TRIG_US  (10),
        .ECHO_DELAY_US(40),
        .US_PER_CM    (58),
        .MAX_DIST_CM  (400),
        .MAX_ECHO_US  (3000),
        .HOLDOFF_US   (60)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .habilita    (habilita),
        .trigger     (trigger),
        .distancia_cm(distancia_cm),
        .echo        (echo),
        .ocupado     (ocupado),
        .medidas     (medidas),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic ciclo(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Trigger high for k cycles starting at the current negedge
    task automatic pulso(input int k);
        trigger = 1'b1;
        ciclo(k);
        trigger = 1'b0;
        t_desce = cyc;
    endtask

    task automatic espera(input logic nivel, input string tag, output int c);
        bit achou;
        achou = 1'b0;
        c = 0;
        for (int i = 0; i < 20000 && !achou; i++) begin
            @(negedge clock);
            if (echo === nivel) begin
                achou = 1'b1;
                c = cyc;
            end
        end
        if (!achou) begin
            verifica(tag, 32'(echo), 32'(nivel));
            c = cyc;
        end
    endtask

    task automatic medir(input int cm, input int esp_larg, input string tag);
        distancia_cm = 9'(cm);
        pulso(20);
        espera(1'b1, {tag, " rise timeout"}, t_sobe);
        verifica({tag, " delay"}, t_sobe - t_desce, DELAY_CYC);
        espera(1'b0, {tag, " fall timeout"}, t_fim);
        verifica({tag, " width"}, t_fim - t_sobe, esp_larg);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int vistos;
        reset = 1'b0;
        habilita = 1'b0;
        trigger = 1'b0;
        distancia_cm = '0;

        ciclo(3);
        verifica("reset echo", 32'(echo), 0);
        verifica("reset ocupado", 32'(ocupado), 0);
        verifica("reset medidas", 32'(medidas), 0);
        verifica("reset estado", 32'(db_estado), 0);
        reset = 1'b1;
        habilita = 1'b1;
        ciclo(5);

        // Basic: 100 cm -> 5800 us -> 11600 cycles
        medir(100, 11600, "basic");
        verifica("basic medidas", 32'(medidas), 1);
        ciclo(130);
        verifica("basic idle estado", 32'(db_estado), 0);
        verifica("basic idle ocupado", 32'(ocupado), 0);

        // Short trigger: 18 cycles (< 20) rejected
        distancia_cm = 9'd100;
        pulso(18);
        ciclo(2);
        verifica("short ocupado before", 32'(ocupado), 1);
        ciclo(1);
        verifica("short ocupado after", 32'(ocupado), 0);
        vistos = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (echo) vistos++;
        end
        verifica("short no echo", vistos, 0);
        verifica("short medidas", 32'(medidas), 1);

        // Out of range and lower in-range boundary
        medir(0, 6000, "oor zero");
        ciclo(130);
        medir(450, 6000, "oor 450");
        ciclo(130);
        medir(1, 116, "one cm");
        ciclo(130);
        verifica("range medidas", 32'(medidas), 4);

        // Ignored trigger during echo with distance change: 20 cm -> 2320 cycles
        distancia_cm = 9'd20;
        pulso(20);
        espera(1'b1, "ignored rise timeout", t_sobe);
        verifica("ignored delay", t_sobe - t_desce, DELAY_CYC);
        ciclo(200);
        distancia_cm = 9'd300;
        pulso(20);
        espera(1'b0, "ignored fall timeout", t_fim);
        verifica("ignored width", t_fim - t_sobe, 2320);
        verifica("ignored medidas", 32'(medidas), 5);
        vistos = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (echo) vistos++;
        end
        verifica("ignored no second echo", vistos, 0);
        verifica("ignored idle estado", 32'(db_estado), 0);

        // Abort through habilita 1000 us into echo
        distancia_cm = 9'd100;
        pulso(20);
        espera(1'b1, "abort rise timeout", t_sobe);
        ciclo(2000);
        verifica("abort echo before", 32'(echo), 1);
        habilita = 1'b0;
        ciclo(1);
        verifica("abort echo", 32'(echo), 0);
        verifica("abort ocupado", 32'(ocupado), 0);
        verifica("abort estado", 32'(db_estado), 0);
        verifica("abort medidas", 32'(medidas), 5);
        habilita = 1'b1;
        ciclo(5);

        // Asynchronous reset 1000 us into echo
        pulso(20);
        espera(1'b1, "reset rise timeout", t_sobe);
        ciclo(2000);
        verifica("areset echo before", 32'(echo), 1);
        reset = 1'b0;
        #1;
        verifica("areset echo", 32'(echo), 0);
        verifica("areset medidas", 32'(medidas), 0);
        verifica("areset ocupado", 32'(ocupado), 0);
        ciclo(2);
        reset = 1'b1;
        ciclo(3);
        medir(74, 8584, "after reset");
        verifica("after reset medidas", 32'(medidas), 1);
        ciclo(130);

        // Holdoff: 60 cycles after fall ignored, 140 cycles after accepted
        medir(5, 580, "hold first");
        ciclo(60);
        trigger = 1'b1;
        ciclo(20);
        trigger = 1'b0;
        verifica("hold pausa estado", 32'(db_estado), 4);
        ciclo(60);
        medir(5, 580, "hold second");
        verifica("hold medidas", 32'(medidas), 3);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
